// File: rtl/mod2011_residue_acc.sv
// mod2011_residue_acc
//   Sums a stream of 11-bit LUT-slice residues modulo MOD. Each frame is a run of
//   beats that ends with in_last. The block emits one fully reduced residue per
//   frame, together with the beat count and a sticky out-of-range flag.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   in_res / in_last are valid this cycle
//   in_ready   out  block accepts a beat this cycle (combinational)
//   in_res     in   residue of one slice, legal range 0..MOD-1
//   in_last    in   this beat closes the frame
//   out_valid  out  out_res / out_cnt / out_err are valid
//   out_ready  in   consumer takes the result this cycle
//   out_res    out  frame sum mod MOD, always 0..MOD-1
//   out_cnt    out  number of beats in the frame, wraps modulo 2^CNT_W
//   out_err    out  at least one beat of the frame had in_res >= MOD
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer.
// in_ready = !out_valid || out_ready, so the result register can drain and be
// refilled by a new last beat on the same edge.

module mod2011_residue_acc #(
    parameter int MOD   = 2011,
    parameter int W     = 11,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_res,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_err
);

    localparam logic [W-1:0] MOD_W  = W'(MOD);
    localparam logic [W:0]   MOD_W1 = (W+1)'(MOD);

    // ACC: no result pending. HOLD: result register full.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic             accept;
    logic             flag;
    logic [W-1:0]     r;
    logic [W:0]       s;
    logic [W-1:0]     acc_next;
    logic [CNT_W-1:0] cnt_next;

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Inputs are below 2^W < 2*MOD, so one conditional subtraction brings an
    // out-of-range residue back into 0..MOD-1. The same holds for acc + r.
    assign flag     = (in_res >= MOD_W);
    assign r        = flag ? (in_res - MOD_W) : in_res;
    assign s        = {1'b0, acc} + {1'b0, r};
    assign acc_next = (s >= MOD_W1) ? W'(s - MOD_W1) : s[W-1:0];
    assign cnt_next = cnt + CNT_W'(1);

    always_comb begin
        state_next = state;
        case (state)
            ACC: begin
                if (accept && in_last) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready && !(accept && in_last)) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            out_res <= '0;
            out_cnt <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_res <= acc_next;
                out_cnt <= cnt_next;
                out_err <= err | flag;
                // Clear on the closing edge so the next frame starts immediately.
                acc     <= '0;
                cnt     <= '0;
                err     <= 1'b0;
            end else begin
                acc <= acc_next;
                cnt <= cnt_next;
                err <= err | flag;
            end
        end
    end

endmodule

// File: tb/tb_mod2011_residue_acc.sv
module tb_mod2011_residue_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_res;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_res;
  logic [6:0]  out_cnt;
  logic        out_err;

  int          tests;
  int          failures;
  logic        rand_rdy;
  logic        mon_en;
  logic [18:0] exp_q[$];

  mod2011_residue_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cnt   (out_cnt),
    .out_err   (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [10:0] res, input logic last);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_res   = res;
    in_last  = last;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [10:0] res,
                           input logic [6:0] cnt, input logic err);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"},   out_res,   res);
    check({tag, "_cnt"},   out_cnt,   cnt);
    check({tag, "_err"},   out_err,   err);
  endtask

  // scoreboard: compare a result on the cycle it is handed over
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {13'd0, out_err, out_cnt, out_res}, 32'hffff_ffff);
      end else begin
        check("sb_result", {13'd0, out_err, out_cnt, out_res}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    tests     = 0;
    failures  = 0;
    rand_rdy  = 1'b0;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_res    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_valid", out_valid, 0);
    check("rst_res",   out_res,   0);
    check("rst_cnt",   out_cnt,   0);
    check("rst_err",   out_err,   0);
    check("rst_ready", in_ready,  1);

    // T1 single-beat frame
    send_beat(11'd5, 1'b1);
    check_out("t1", 11'd5, 7'd1, 1'b0);
    tick();
    check("t1_drain", out_valid, 0);

    // T2 wrap-around sums, with an idle gap mid-frame
    send_beat(11'd2000, 1'b0);
    tick();
    tick();
    send_beat(11'd20, 1'b1);
    check_out("t2a", 11'd9, 7'd2, 1'b0);
    send_beat(11'd2010, 1'b0);
    send_beat(11'd2010, 1'b0);
    send_beat(11'd2010, 1'b1);
    check_out("t2b", 11'd2008, 7'd3, 1'b0);

    // T3 out-of-range beat sets error only for its own frame
    send_beat(11'd2047, 1'b0);
    send_beat(11'd0, 1'b1);
    check_out("t3a", 11'd36, 7'd2, 1'b1);
    send_beat(11'd7, 1'b1);
    check_out("t3b", 11'd7, 7'd1, 1'b0);
    tick();

    // T4 back-pressure, then drain and refill on the same edge
    out_ready = 1'b0;
    send_beat(11'd4, 1'b1);
    check_out("t4a", 11'd4, 7'd1, 1'b0);
    in_valid = 1'b1;
    in_res   = 11'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_ready", in_ready, 0);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_res",   out_res,   4);
      check("t4_stall_cnt",   out_cnt,   1);
      tick();
    end
    out_ready = 1'b1;
    send_beat(11'd9, 1'b1);
    check_out("t4b", 11'd9, 7'd1, 1'b0);
    tick();
    check("t4_drain", out_valid, 0);

    // T5 asynchronous reset mid-frame
    send_beat(11'd100, 1'b0);
    send_beat(11'd200, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_res",   out_res,   0);
    check("t5_cnt",   out_cnt,   0);
    check("t5_err",   out_err,   0);
    tick();
    rst_n = 1'b1;
    tick();
    send_beat(11'd1, 1'b0);
    send_beat(11'd2, 1'b1);
    check_out("t5b", 11'd3, 7'd2, 1'b0);
    tick();

    // T6 random frames, random valid gaps and random out_ready
    mon_en   = 1'b1;
    rand_rdy = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int   len;
      int   sum;
      logic e;
      len = (f == 0) ? 84 : $urandom_range(1, 84);
      sum = 0;
      e   = 1'b0;
      for (int b = 0; b < len; b++) begin
        int v;
        v = ($urandom_range(0, 19) == 0) ? $urandom_range(2011, 2047) : $urandom_range(0, 2010);
        if (v >= 2011) e = 1'b1;
        sum = (sum + (v % 2011)) % 2011;
        if (b == len - 1) exp_q.push_back({e, 7'(len % 128), 11'(sum)});
        repeat ($urandom_range(0, 2)) tick();
        send_beat(11'(v), (b == len - 1));
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check("t6_queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
